// File: rtl/morse_tx_sequencer.sv
// morse_tx_sequencer: PS/2 set-2 make codes -> queued Morse keying with unit-based timing
// Optional feature: define MORSE_TX_DIGITS_EN to map the number-row keys to digit patterns
module morse_tx_sequencer #(
    parameter int UNIT_CYCLES = 1200000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ps2_received_data,
    input  logic       ps2_received_data_strb,
    output logic       dit_out,
    output logic       dah_out,
    output logic       morse_code_out,
    output logic       busy,
    output logic       overflow,
    output logic       unsupported
);
    localparam int UW = $clog2(UNIT_CYCLES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [UW-1:0] UNIT_MAX = UW'(UNIT_CYCLES - 1);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, MARK, SPACE, CHAR_GAP, WORD_GAP} state_t;

    state_t        state;
    logic          skip;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_nxt;
    logic [UW-1:0] unit_cnt;
    logic [1:0]    elem_cnt;
    logic [2:0]    rem;
    logic [4:0]    bits;
    logic [8:0]    rom;
    logic          is_prefix;
    logic          is_char;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          unit_done;
    logic          fsm_idle_nxt;

    // Pattern ROM: {valid, length, elements MSB first (1 = dah)}; length 0 is the word-gap token
    always_comb begin
        rom = 9'h000;
        case (ps2_received_data)
            8'h1C: rom = {1'b1, 3'd2, 5'b01000};
            8'h32: rom = {1'b1, 3'd4, 5'b10000};
            8'h21: rom = {1'b1, 3'd4, 5'b10100};
            8'h23: rom = {1'b1, 3'd3, 5'b10000};
            8'h24: rom = {1'b1, 3'd1, 5'b00000};
            8'h2B: rom = {1'b1, 3'd4, 5'b00100};
            8'h34: rom = {1'b1, 3'd3, 5'b11000};
            8'h33: rom = {1'b1, 3'd4, 5'b00000};
            8'h43: rom = {1'b1, 3'd2, 5'b00000};
            8'h3B: rom = {1'b1, 3'd4, 5'b01110};
            8'h42: rom = {1'b1, 3'd3, 5'b10100};
            8'h4B: rom = {1'b1, 3'd4, 5'b01000};
            8'h3A: rom = {1'b1, 3'd2, 5'b11000};
            8'h31: rom = {1'b1, 3'd2, 5'b10000};
            8'h44: rom = {1'b1, 3'd3, 5'b11100};
            8'h4D: rom = {1'b1, 3'd4, 5'b01100};
            8'h15: rom = {1'b1, 3'd4, 5'b11010};
            8'h2D: rom = {1'b1, 3'd3, 5'b01000};
            8'h1B: rom = {1'b1, 3'd3, 5'b00000};
            8'h2C: rom = {1'b1, 3'd1, 5'b10000};
            8'h3C: rom = {1'b1, 3'd3, 5'b00100};
            8'h2A: rom = {1'b1, 3'd4, 5'b00010};
            8'h1D: rom = {1'b1, 3'd3, 5'b01100};
            8'h22: rom = {1'b1, 3'd4, 5'b10010};
            8'h35: rom = {1'b1, 3'd4, 5'b10110};
            8'h1A: rom = {1'b1, 3'd4, 5'b11000};
            8'h29: rom = {1'b1, 3'd0, 5'b00000};
`ifdef MORSE_TX_DIGITS_EN
            8'h45: rom = {1'b1, 3'd5, 5'b11111};
            8'h16: rom = {1'b1, 3'd5, 5'b01111};
            8'h1E: rom = {1'b1, 3'd5, 5'b00111};
            8'h26: rom = {1'b1, 3'd5, 5'b00011};
            8'h25: rom = {1'b1, 3'd5, 5'b00001};
            8'h2E: rom = {1'b1, 3'd5, 5'b00000};
            8'h36: rom = {1'b1, 3'd5, 5'b10000};
            8'h3D: rom = {1'b1, 3'd5, 5'b11000};
            8'h3E: rom = {1'b1, 3'd5, 5'b11100};
            8'h46: rom = {1'b1, 3'd5, 5'b11110};
`endif
            default: rom = 9'h000;
        endcase
    end

    // Strobe qualification, FIFO handshakes and the FSM's next-idle condition for busy
    always_comb begin
        is_prefix    = (ps2_received_data == 8'hF0) || (ps2_received_data == 8'hE0);
        is_char      = ps2_received_data_strb && !is_prefix && !skip;
        accept       = is_char && rom[8];
        full         = (count == FULL_CNT);
        push         = accept && !full;
        pop          = (state == IDLE) && (count != '0);
        count_nxt    = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        unit_done    = (unit_cnt == '0) && (elem_cnt == 2'd0);
        fsm_idle_nxt = ((state == IDLE) && (count == '0)) ||
                       (((state == CHAR_GAP) || (state == WORD_GAP)) && unit_done);
    end

    // Prefix filter, FIFO pointers/count and the registered status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip        <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            unsupported <= 1'b0;
        end else begin
            if (ps2_received_data_strb) skip <= is_prefix;
            wr_ptr      <= wr_ptr + {{(PW-1){1'b0}}, push};
            rd_ptr      <= rd_ptr + {{(PW-1){1'b0}}, pop};
            count       <= count_nxt;
            busy        <= (count_nxt != '0) || !fsm_idle_nxt;
            overflow    <= accept && full;
            unsupported <= is_char && !rom[8];
        end
    end

    // FIFO storage holds {length, elements}; no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rom[7:0];
    end

    // Element and gap timing FSM; key outputs are registered with the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            unit_cnt       <= '0;
            elem_cnt       <= 2'd0;
            rem            <= 3'd0;
            bits           <= 5'd0;
            dit_out        <= 1'b0;
            dah_out        <= 1'b0;
            morse_code_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= LOAD;
                        rem   <= mem[rd_ptr][7:5];
                        bits  <= mem[rd_ptr][4:0];
                    end
                end
                LOAD: begin
                    unit_cnt <= UNIT_MAX;
                    if (rem == 3'd0) begin
                        state    <= WORD_GAP;
                        elem_cnt <= 2'd3;
                    end else begin
                        state          <= MARK;
                        rem            <= rem - 3'd1;
                        elem_cnt       <= bits[4] ? 2'd2 : 2'd0;
                        dit_out        <= ~bits[4];
                        dah_out        <= bits[4];
                        morse_code_out <= 1'b1;
                    end
                end
                default: begin
                    if (!unit_done) begin
                        unit_cnt <= (unit_cnt == '0) ? UNIT_MAX : unit_cnt - 1'b1;
                        elem_cnt <= (unit_cnt == '0) ? elem_cnt - 2'd1 : elem_cnt;
                    end else if (state == MARK) begin
                        state          <= (rem == 3'd0) ? CHAR_GAP : SPACE;
                        unit_cnt       <= UNIT_MAX;
                        elem_cnt       <= (rem == 3'd0) ? 2'd2 : 2'd0;
                        bits           <= {bits[3:0], 1'b0};
                        dit_out        <= 1'b0;
                        dah_out        <= 1'b0;
                        morse_code_out <= 1'b0;
                    end else if (state == SPACE) begin
                        state          <= MARK;
                        rem            <= rem - 3'd1;
                        unit_cnt       <= UNIT_MAX;
                        elem_cnt       <= bits[4] ? 2'd2 : 2'd0;
                        dit_out        <= ~bits[4];
                        dah_out        <= bits[4];
                        morse_code_out <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_morse_tx_sequencer.sv
// tb_morse_tx_sequencer: directed stimulus, per-cycle check against a timeline model of Morse keying
module tb_morse_tx_sequencer;
    localparam int MAXC = 16384;
    localparam int UNIT = 4;
    localparam byte DASH = "-";

    logic       clk;
    logic       rst_n;
    logic [7:0] ps2_received_data;
    logic       ps2_received_data_strb;
    logic       dit_out;
    logic       dah_out;
    logic       morse_code_out;
    logic       busy;
    logic       overflow;
    logic       unsupported;

    morse_tx_sequencer #(.UNIT_CYCLES(UNIT), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ps2_received_data(ps2_received_data),
        .ps2_received_data_strb(ps2_received_data_strb),
        .dit_out(dit_out),
        .dah_out(dah_out),
        .morse_code_out(morse_code_out),
        .busy(busy),
        .overflow(overflow),
        .unsupported(unsupported)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   chk_en = 0;
    bit   e_dit [MAXC];
    bit   e_dah [MAXC];
    bit   e_busy [MAXC];
    bit   e_ovf [MAXC];
    bit   e_uns [MAXC];
    int   free_at = 0;
    bit   m_skip = 0;
    int   pops [$];
    int   mk_start [$];
    int   mk_len [$];
    bit   mk_dah [$];
    bit   prev_key = 0;
    int   ovf_cnt = 0;
    int   uns_cnt = 0;
    logic [5:0] got;
    logic [5:0] want;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Morse alphabet as dot/dash text; " " is the word gap, "" means no mapping
    function automatic string morse_of(input logic [7:0] c);
        case (c)
            8'h1C: return ".-";    8'h32: return "-...";  8'h21: return "-.-.";
            8'h23: return "-..";   8'h24: return ".";     8'h2B: return "..-.";
            8'h34: return "--.";   8'h33: return "....";  8'h43: return "..";
            8'h3B: return ".---";  8'h42: return "-.-";   8'h4B: return ".-..";
            8'h3A: return "--";    8'h31: return "-.";    8'h44: return "---";
            8'h4D: return ".--.";  8'h15: return "--.-";  8'h2D: return ".-.";
            8'h1B: return "...";   8'h2C: return "-";     8'h3C: return "..-";
            8'h2A: return "...-";  8'h1D: return ".--";   8'h22: return "-..-";
            8'h35: return "-.--";  8'h1A: return "--..";  8'h29: return " ";
`ifdef MORSE_TX_DIGITS_EN
            8'h45: return "-----"; 8'h16: return ".----"; 8'h1E: return "..---";
            8'h26: return "...--"; 8'h25: return "....-"; 8'h2E: return ".....";
            8'h36: return "-...."; 8'h3D: return "--...";  8'h3E: return "---..";
            8'h46: return "----.";
`endif
            default: return "";
        endcase
    endfunction

    // Schedule the whole output timeline of a byte strobed in cycle n
    function automatic void model_push(input logic [7:0] code, input int n);
        string p;
        int pc;
        int t;
        int occ;
        if (code == 8'hF0 || code == 8'hE0) begin m_skip = 1; return; end
        if (m_skip) begin m_skip = 0; return; end
        p = morse_of(code);
        if (p.len() == 0) begin e_uns[n+1] = 1; return; end
        occ = 0;
        foreach (pops[i]) if (pops[i] >= n) occ++;
        if (occ >= 4) begin e_ovf[n+1] = 1; return; end
        pc = (n + 1 > free_at) ? n + 1 : free_at;
        pops.push_back(pc);
        t = pc + 2;
        if (p == " ") t += 4 * UNIT;
        else begin
            for (int i = 0; i < p.len(); i++) begin
                int l;
                l = (p[i] == DASH) ? 3 * UNIT : UNIT;
                for (int k = 0; k < l; k++) begin
                    if (p[i] == DASH) e_dah[t+k] = 1; else e_dit[t+k] = 1;
                end
                t += l;
                if (i < p.len() - 1) t += UNIT;
            end
            t += 3 * UNIT;
        end
        for (int k = n + 1; k < t; k++) e_busy[k] = 1;
        free_at = t;
    endfunction

    function automatic void model_reset(input int n);
        for (int k = n; k < MAXC; k++) begin
            e_dit[k] = 0; e_dah[k] = 0; e_busy[k] = 0; e_ovf[k] = 0; e_uns[k] = 0;
        end
        pops.delete();
        m_skip = 0;
        free_at = 0;
    endfunction

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            want = {e_busy[cyc], e_dit[cyc], e_dah[cyc], e_dit[cyc] | e_dah[cyc], e_ovf[cyc], e_uns[cyc]};
            got  = {busy, dit_out, dah_out, morse_code_out, overflow, unsupported};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL cycle_%0d outputs{busy,dit,dah,key,ovf,uns} got %b want %b", cyc, got, want);
            end
        end
    end

    // Mark and pulse recorder for the hand-computed checks
    always @(negedge clk) begin
        if (morse_code_out === 1'b1 && !prev_key) begin
            mk_start.push_back(cyc);
            mk_len.push_back(0);
            mk_dah.push_back(dah_out === 1'b1);
        end
        if (morse_code_out === 1'b1) mk_len[mk_len.size()-1] = mk_len[mk_len.size()-1] + 1;
        prev_key = (morse_code_out === 1'b1);
        if (overflow === 1'b1) ovf_cnt++;
        if (unsupported === 1'b1) uns_cnt++;
    end

    function automatic int st(input int i);
        return (i < mk_start.size()) ? mk_start[i] : -1;
    endfunction

    function automatic int ln(input int i);
        return (i < mk_len.size()) ? mk_len[i] : -1;
    endfunction

    function automatic int dh(input int i);
        return (i < mk_dah.size()) ? int'(mk_dah[i]) : -1;
    endfunction

    function automatic int count_kind(input bit d);
        int c;
        c = 0;
        foreach (mk_dah[i]) if (mk_dah[i] == d) c++;
        return c;
    endfunction

    task automatic check(input string name, input int g, input int w);
        tests++;
        if (g != w) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, g, w);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] code);
        ps2_received_data = code;
        ps2_received_data_strb = 1;
        model_push(code, cyc);
        tick();
        ps2_received_data_strb = 0;
    endtask

    task automatic clear_mon();
        mk_start.delete();
        mk_len.delete();
        mk_dah.delete();
        ovf_cnt = 0;
        uns_cnt = 0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 4000 && busy !== 1'b0; i++) tick();
        check({name, "_idle_timeout"}, int'(busy === 1'b0), 1);
    endtask

    initial begin
        int n;
        rst_n = 0;
        ps2_received_data = 8'h00;
        ps2_received_data_strb = 0;
        repeat (3) tick();
        check("reset_outputs", int'({dit_out, dah_out, morse_code_out, busy, overflow, unsupported}), 0);
        rst_n = 1;
        chk_en = 1;
        repeat (2) tick();

        clear_mon(); n = cyc;
        strobe(8'h24);
        check("model_pin_e_first_dit", int'(e_dit[n+3]), 1);
        check("model_pin_e_after_dit", int'(e_dit[n+7]), 0);
        check("model_pin_e_busy_end", int'(e_busy[n+19]), 0);
        wait_idle("e");
        check("e_busy_fall_cycle", cyc, n + 19);
        repeat (2) tick();
        check("e_mark_count", mk_start.size(), 1);
        check("e_mark_start", st(0), n + 3);
        check("e_mark_len", ln(0), 4);
        check("e_is_dit", dh(0), 0);

        clear_mon(); n = cyc;
        strobe(8'h2C);
        wait_idle("t");
        repeat (2) tick();
        check("t_mark_count", mk_start.size(), 1);
        check("t_mark_start", st(0), n + 3);
        check("t_dah_len", ln(0), 12);
        check("t_is_dah", dh(0), 1);

        clear_mon(); n = cyc;
        strobe(8'h1C);
        wait_idle("a");
        repeat (2) tick();
        check("a_mark_count", mk_start.size(), 2);
        check("a_dit_len", ln(0), 4);
        check("a_inter_gap", st(1) - st(0) - ln(0), 4);
        check("a_dah_len", ln(1), 12);
        check("a_order", dh(0) * 2 + dh(1), 1);

        clear_mon();
        strobe(8'hF0); strobe(8'h24);
        strobe(8'hE0); strobe(8'h75);
        strobe(8'hF0); strobe(8'hF0); strobe(8'h1C);
        repeat (20) tick();
        check("prefix_no_marks", mk_start.size(), 0);
        check("prefix_no_unsupported", uns_cnt, 0);
        check("prefix_no_overflow", ovf_cnt, 0);
        check("prefix_not_busy", int'(busy), 0);
        n = cyc;
        strobe(8'h24);
        wait_idle("prefix_after");
        repeat (2) tick();
        check("prefix_after_dit_start", st(0), n + 3);

        clear_mon(); n = cyc;
        strobe(8'h24); strobe(8'h29); strobe(8'h24);
        wait_idle("word");
        repeat (2) tick();
        check("word_mark_count", mk_start.size(), 2);
        check("word_gap_fall_to_rise", st(1) - (st(0) + ln(0)), 32);

        clear_mon(); n = cyc;
        strobe(8'h2C);
        repeat (3) tick();
        check("ovf_in_dah", int'(dah_out), 1);
        repeat (5) strobe(8'h1B);
        wait_idle("ovf");
        repeat (2) tick();
        check("ovf_pulses", ovf_cnt, 1);
        check("ovf_dits", count_kind(0), 12);
        check("ovf_dahs", count_kind(1), 1);

        clear_mon();
        strobe(8'h5A);
        repeat (20) tick();
        check("unsup_5a_pulses", uns_cnt, 1);
        check("unsup_5a_marks", mk_start.size(), 0);

        clear_mon();
        strobe(8'h45);
        repeat (2) tick();
        wait_idle("digit");
        repeat (2) tick();
`ifdef MORSE_TX_DIGITS_EN
        check("digit0_dahs", count_kind(1), 5);
        check("digit0_marks", mk_start.size(), 5);
        check("digit0_unsup", uns_cnt, 0);
`else
        check("digit0_unsup", uns_cnt, 1);
        check("digit0_marks", mk_start.size(), 0);
`endif

        clear_mon();
        strobe(8'h2C);
        repeat (6) tick();
        strobe(8'h24); strobe(8'h24);
        check("rst_mid_dah", int'(dah_out), 1);
        #1;
        rst_n = 0;
        model_reset(cyc);
        #1;
        check("rst_async_outputs", int'({dit_out, dah_out, morse_code_out, busy, overflow, unsupported}), 0);
        repeat (3) tick();
        rst_n = 1;
        clear_mon();
        repeat (40) tick();
        check("rst_fifo_empty_busy", int'(busy), 0);
        check("rst_fifo_empty_marks", mk_start.size(), 0);
        n = cyc;
        strobe(8'h24);
        wait_idle("rst_after");
        repeat (2) tick();
        check("rst_after_dit_start", st(0), n + 3);
        check("rst_after_dit_len", ln(0), 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
